// File: rtl/dsp_pkg.sv
// Shared Q15 fixed-point constants and primitives for the EQ and level-meter paths.
package dsp_pkg;

  localparam int Q_FP       = 15;
  localparam int L1         = int'(1.3465 * 2.0**15);
  localparam int L2         = int'(0.3465 * 2.0**15);
  localparam int DB_PER_OCT = int'(6.0206 * 2.0**15);

  typedef enum logic [1:0] {
    S_IDLE,
    S_NORM,
    S_POLY,
    S_OUT
  } lvl_state_t;

  // Q15 multiply, truncating toward minus infinity.
  function automatic logic signed [31:0] qmul(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
    logic signed [63:0] prod;
    prod = 64'(a) * 64'(b);
    return 32'(prod >>> Q_FP);
  endfunction

  // Saturating add.
  function automatic logic signed [31:0] qadd(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
    logic signed [32:0] sum;
    sum = 33'(a) + 33'(b);
    if (sum[32] != sum[31])
      return sum[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/band_level_meter_log2.sv
// Peak -> dB converter: bit-serial normalise, quadratic log2 of the mantissa,
// scale to dB with symmetric rounding and clamping.
module level_log2
  import dsp_pkg::*;
#(
  parameter int DB_FLOOR = -96,
  parameter int DB_CEIL  = 96
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [30:0]        i_peak,
  output logic               o_busy,
  output logic               o_done,
  output logic signed [15:0] o_result
);

  localparam logic signed [63:0] HALF = 64'sd1 <<< 29;

  lvl_state_t         r_state, w_state_next;
  logic [30:0]        r_x;
  logic [4:0]         r_p;
  logic               r_phase;
  logic signed [31:0] r_log2m;
  logic signed [15:0] r_result;

  logic signed [31:0] w_f, w_log2m, w_pint, w_exp, w_lg;
  logic signed [63:0] w_db, w_rnd;
  logic signed [15:0] w_clamped;

  assign w_f     = {17'd0, r_x[29:15]};
  assign w_log2m = qmul(w_f, qadd(L1, -qmul(L2, w_f)));
  assign w_pint  = {27'd0, r_p};
  assign w_exp   = (w_pint - Q_FP) <<< Q_FP;
  assign w_lg    = qadd(w_exp, r_log2m);
  assign w_db    = 64'(w_lg) * 64'(DB_PER_OCT);
  // Round half away from zero on the Q30 product.
  assign w_rnd   = w_db[63] ? -((-w_db + HALF) >>> 30) : ((w_db + HALF) >>> 30);

  always_comb begin
    if (w_rnd > 64'(DB_CEIL))
      w_clamped = 16'(DB_CEIL);
    else if (w_rnd < 64'(DB_FLOOR))
      w_clamped = 16'(DB_FLOOR);
    else
      w_clamped = w_rnd[15:0];
  end

  always_comb begin
    w_state_next = r_state;
    o_busy       = (r_state != S_IDLE);
    o_done       = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_state_next = S_NORM;
      S_NORM: begin
        if (r_x == '0)
          w_state_next = S_OUT;
        else if (r_x[30])
          w_state_next = S_POLY;
      end
      S_POLY: if (r_phase) w_state_next = S_OUT;
      S_OUT: begin
        o_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x      <= '0;
      r_p      <= '0;
      r_phase  <= 1'b0;
      r_log2m  <= '0;
      r_result <= 16'(DB_FLOOR);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_x     <= i_peak;
            r_p     <= 5'd30;
            r_phase <= 1'b0;
          end
        end
        S_NORM: begin
          if (r_x == '0) begin
            r_result <= 16'(DB_FLOOR);
          end else if (!r_x[30]) begin
            r_x <= r_x << 1;
            r_p <= r_p - 5'd1;
          end
        end
        S_POLY: begin
          if (!r_phase) begin
            r_log2m <= w_log2m;
            r_phase <= 1'b1;
          end else begin
            r_result <= w_clamped;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_result = r_result;

endmodule

// File: rtl/band_level_meter.sv
// Per-band level meter: windowed peak |sample| tracker feeding a log2-based
// dB converter, result handed out over valid/ready.
module band_level_meter
  import dsp_pkg::*;
#(
  parameter int WIN_LEN  = 512,
  parameter int DB_FLOOR = -96,
  parameter int DB_CEIL  = 96
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [31:0]        i_data,
  output logic signed [15:0] o_level,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_overrun
);

  localparam int CNT_W = $clog2(WIN_LEN);

  logic [CNT_W-1:0]   r_count;
  logic [30:0]        r_peak;
  logic signed [15:0] r_level;
  logic               r_valid;
  logic               r_overrun;

  logic [30:0]        w_neg, w_abs, w_win_peak;
  logic               w_close, w_pending, w_start, w_busy, w_done;
  logic signed [15:0] w_result;

  // Low 31 bits of the two's-complement negation are |x| for every x but -2^31.
  assign w_neg      = 31'd0 - i_data[30:0];
  assign w_abs      = (i_data == 32'h8000_0000) ? 31'h7FFF_FFFF :
                      (i_data[31] ? w_neg : i_data[30:0]);
  assign w_win_peak = (w_abs > r_peak) ? w_abs : r_peak;
  assign w_close    = i_valid && (r_count == CNT_W'(WIN_LEN - 1));
  assign w_pending  = r_valid & ~i_ready;
  assign w_start    = w_close & ~w_busy & ~w_pending;

  level_log2 #(
    .DB_FLOOR (DB_FLOOR),
    .DB_CEIL  (DB_CEIL)
  ) u_log2 (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (w_start),
    .i_peak   (w_win_peak),
    .o_busy   (w_busy),
    .o_done   (w_done),
    .o_result (w_result)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count   <= '0;
      r_peak    <= '0;
      r_level   <= 16'(DB_FLOOR);
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (i_valid) begin
        r_count <= r_count + CNT_W'(1);
        r_peak  <= w_close ? '0 : w_win_peak;
      end
      r_overrun <= w_close & ~w_start;
      if (w_done) begin
        r_level <= w_result;
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_level   = r_level;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_band_level_meter.sv
// Scoreboard bench for band_level_meter: expected dB levels queued at window close.
module tb_band_level_meter;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               i_valid = 1'b0;
  logic [31:0]        i_data = '0;
  logic               i_ready = 1'b1;
  logic signed [15:0] o_level;
  logic               o_valid;
  logic               o_overrun;

  always #5 clk = ~clk;

  band_level_meter dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .o_level   (o_level),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_overrun (o_overrun)
  );

  typedef struct {
    int    exp;
    int    tol;
    string tag;
  } exp_t;

  exp_t   sb_q[$];
  exp_t   e_mon;
  int     n_checks = 0;
  int     n_fail   = 0;
  int     n_ovr    = 0;
  longint m_peak   = 0;
  int     m_cnt    = 0;
  int     m_tol    = 0;
  bit     m_drop   = 1'b0;
  string  m_tag    = "";

  task automatic check(input string tag, input longint obs, input longint exp,
                       input longint tol);
    longint d;
    d = obs - exp;
    if (d < 0) d = -d;
    n_checks++;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic int ref_db(input longint pk);
    real r;
    int  q;
    if (pk == 0) return -96;
    r = 20.0 * $log10(real'(pk) / 32768.0);
    q = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    if (q > 96) q = 96;
    if (q < -96) q = -96;
    return q;
  endfunction

  task automatic send(input logic [31:0] d);
    longint a;
    exp_t   e;
    a = $signed(d);
    if (a < 0) a = -a;
    if (a > 64'sd2147483647) a = 64'sd2147483647;
    if (a > m_peak) m_peak = a;
    i_valid = 1'b1;
    i_data  = d;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    m_cnt++;
    if (m_cnt == 512) begin
      m_cnt = 0;
      if (m_drop) begin
        m_drop = 1'b0;
      end else begin
        e.exp = ref_db(m_peak);
        e.tol = m_tol;
        e.tag = m_tag;
        sb_q.push_back(e);
      end
      m_peak = 0;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic window_fill(input logic [31:0] d);
    for (int i = 0; i < 512; i++) send(d);
  endtask

  task automatic window_single(input logic [31:0] d, input int pos);
    for (int i = 0; i < 512; i++) send((i == pos) ? d : 32'd0);
  endtask

  task automatic window_rand(input longint pk);
    int          pos;
    longint      v;
    logic [31:0] d;
    pos = int'($urandom_range(511, 0));
    for (int i = 0; i < 512; i++) begin
      if (i == pos) v = pk;
      else if (pk > 1) v = longint'($urandom_range(32'(pk - 1), 0));
      else v = 0;
      d = 32'(v);
      if ($urandom_range(1, 0) == 1) d = 32'(-v);
      send(d);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", sb_q.size(), 0, 0);
    sb_q.delete();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (o_overrun) n_ovr++;
      if (o_valid && i_ready) begin
        if (sb_q.size() == 0) begin
          check("spurious_valid", 1, 0, 0);
        end else begin
          e_mon = sb_q.pop_front();
          $display("xfer %s level=%0d exp=%0d", e_mon.tag, o_level, e_mon.exp);
          check(e_mon.tag, o_level, e_mon.exp, e_mon.tol);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int     lat;
    int     ovr0;
    int     k;
    real    v;
    longint pk;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", o_valid, 0, 0);
    check("rst_level", o_level, -96, 0);
    check("rst_ovr", o_overrun, 0, 0);
    rst = 1'b0;
    tick(2);

    m_tag = "one";
    window_fill(32'h0000_8000);
    lat = 0;
    while (!o_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("lat_one", (lat <= 35) ? 1 : 0, 1, 0);
    drain();

    m_tag = "half";
    window_single(32'h0000_4000, 100);
    m_tag = "ten";
    window_single(32'h0005_0000, 300);
    drain();

    m_tag = "pre_rst";
    window_fill(32'h0000_8000);
    tick(5);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", o_valid, 0, 0);
    check("arst_level", o_level, -96, 0);
    sb_q.delete();
    m_cnt  = 0;
    m_peak = 0;
    tick(2);
    rst = 1'b0;
    tick(40);
    m_tag = "post_rst";
    window_single(32'h0000_2000, 0);
    drain();

    m_tag = "min_neg";
    window_single(32'h8000_0000, 7);
    m_tag = "zero";
    window_fill(32'h0000_0000);
    drain();

    i_ready = 1'b0;
    m_tag = "held";
    window_fill(32'h0000_8000);
    tick(40);
    check("held_valid", o_valid, 1, 0);
    check("held_level", o_level, 0, 0);
    ovr0   = n_ovr;
    m_drop = 1'b1;
    window_single(32'h0000_4000, 5);
    tick(40);
    check("ovr_once", n_ovr - ovr0, 1, 0);
    check("held_level2", o_level, 0, 0);
    check("held_valid2", o_valid, 1, 0);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    check("valid_clr", o_valid, 0, 0);
    drain();

    m_tol = 1;
    ovr0  = n_ovr;
    v     = 1.0 / 32768.0;
    k     = 0;
    while (v <= 65536.0) begin
      pk = longint'(v * 32768.0);
      if (pk > 64'sd2147483647) pk = 64'sd2147483647;
      if (pk < 1) pk = 1;
      m_tag = $sformatf("sweep%0d_pk%0d", k, pk);
      window_rand(pk);
      v = v * 1.21;
      k++;
    end
    drain();
    check("ovr_sweep", n_ovr - ovr0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
